serial_adder: RTL and testbench

- Bit-serial adder built around one full-adder cell: sum bit = A^B^C, carry = A·B | (A^B)·C.
- Streams two WIDTH-bit operands LSB-first through that cell and holds the running carry in a flip-flop.
- Shifts sum bits into a result register and presents the sum and carry-out with a done pulse.
- Sits downstream of the combinational full-adder stage: it supplies that stage's inputs each cycle and consumes its F/C1 outputs, turning the 1-bit cell into a multi-bit sequential adder.

---
 rtl/serial_adder.sv | 73 +++++++
 tb/tb_serial_adder.sv | 119 +++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder streaming two WIDTH-bit operands LSB-first through one full-adder cell.
// Define SERIAL_ADDER_OVF_EN to add the OVF (two's-complement overflow) output.
module serial_adder #(
  parameter int WIDTH = 8
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C0,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] F,
  output logic             C1
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             OVF
`endif
);
  localparam int CNT_W = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, next;
  logic [WIDTH-1:0] sa, sb, sum, sum_next;
  logic [CNT_W-1:0] cnt;
  logic carry, s, co, last;
  assign s = sa[0] ^ sb[0] ^ carry;
  assign co = (sa[0] & sb[0]) | ((sa[0] ^ sb[0]) & carry);
  assign sum_next = {s, sum[WIDTH-1:1]};
  assign last = state == RUN && cnt == CNT_W'(WIDTH - 1);
  assign busy = state == RUN;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    next = state == IDLE ? (start ? RUN : IDLE) :
           state == RUN  ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sa <= '0;
      sb <= '0;
      sum <= '0;
      carry <= 1'b0;
      cnt <= '0;
      F <= '0;
      C1 <= 1'b0;
    end else if (state == IDLE && start) begin
      sa <= A;
      sb <= B;
      carry <= C0;
      cnt <= '0;
      sum <= '0;
    end else if (state == RUN) begin
      sum <= sum_next;
      sa <= sa >> 1;
      sb <= sb >> 1;
      carry <= co;
      cnt <= cnt + 1'b1;
      if (last) begin
        F <= sum_next;
        C1 <= co;
      end
    end
`ifdef SERIAL_ADDER_OVF_EN
  // carry FF holds the carry into the MSB while the last bit is processed
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) OVF <= 1'b0;
    else if (last) OVF <= carry ^ co;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed-vector self-checking bench for serial_adder (WIDTH=8).
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n, start, C0, busy, done, C1;
  logic [7:0] A, B, F;
  int tests = 0;
  int fails = 0;
`ifdef SERIAL_ADDER_OVF_EN
  logic OVF;
`endif
  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .C0(C0),
    .busy(busy), .done(done), .F(F), .C1(C1)
`ifdef SERIAL_ADDER_OVF_EN
    , .OVF(OVF)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // na/nb/~c are driven right after the accepting edge and must not affect the result
  task automatic add(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic [7:0] na, input logic [7:0] nb,
                     input logic [7:0] ef, input logic ec, input string tag);
    int n;
    @(negedge clk);
    A = a; B = b; C0 = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = na; B = nb; C0 = ~c;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check({tag, " busy_cycles"}, n, 8);
    check({tag, " done"}, done, 1);
    check({tag, " busy_low"}, busy, 0);
    check({tag, " F"}, F, ef);
    check({tag, " C1"}, C1, ec);
    @(negedge clk);
    check({tag, " done_pulse"}, done, 0);
  endtask
  initial begin
    int prev, cnt;
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; C0 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst F", F, 0);
    check("rst C1", C1, 0);
    rst_n = 1'b1;
    add(8'h35, 8'h4A, 1'b0, 8'h35, 8'h4A, 8'h7F, 1'b0, "35+4A");
    add(8'hFF, 8'h01, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, "FF+01");
    add(8'hFF, 8'h00, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b1, "FF+00+1");
    // start held high: one result every WIDTH+2 cycles
    @(negedge clk);
    A = 8'h10; B = 8'h20; C0 = 1'b0; start = 1'b1;
    prev = -1; cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done) begin
        cnt++;
        check("held F", F, 8'h30);
        check("held both", busy, 0);
        if (prev >= 0) check("held gap", i - prev, 10);
        prev = i;
      end
    end
    start = 1'b0;
    check("held count", cnt, 5);
    // reset asserted while bit 4 is in flight
    @(negedge clk);
    A = 8'hAA; B = 8'h55; C0 = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort F", F, 0);
    check("abort C1", C1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    check("abort no_done", cnt, 0);
    add(8'hAA, 8'h55, 1'b0, 8'hAA, 8'h55, 8'hFF, 1'b0, "AA+55");
    add(8'h01, 8'h01, 1'b0, 8'hFF, 8'hFF, 8'h02, 1'b0, "late_change");
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (F !== 8'h02 || C1 !== 1'b0 || done || busy) cnt++;
    end
    check("hold idle", cnt, 0);
`ifdef SERIAL_ADDER_OVF_EN
    add(8'h7F, 8'h01, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, "7F+01");
    check("7F+01 OVF", OVF, 1);
    add(8'hFF, 8'h01, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, "ovf FF+01");
    check("FF+01 OVF", OVF, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
